// File: rtl/fc28_pkg.sv
// rtl/fc28_pkg.sv - shared types, defaults and helpers for the FC-28 sampler
//
// Purpose : state encoding, default timing constants (50 MHz system clock)
//           and the counter-width helper used by fc28_sampler.
// Ports   : none (package).

package fc28_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_SAMPLE,
    ST_DONE_OK,
    ST_DONE_ERR
  } state_e;

  localparam int unsigned DEF_SETTLE_CYCLES   = 500000;    // 10 ms supply settle
  localparam int unsigned DEF_PERIOD_CYCLES   = 50000000;  // 1 s between readings
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 5000;
  localparam int unsigned DEF_WINDOW_CYCLES   = 50000;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width able to hold max_val itself (the window counter reaches
  // WINDOW_CYCLES, not WINDOW_CYCLES-1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fc28_sync.sv
// rtl/fc28_sync.sv - N-stage single-bit synchroniser with async reset
//
// Purpose : brings an asynchronous sensor line into the clk domain. Shared
//           by every sensor DO input in the design.
// Ports   : clk      - destination clock
//           reset_n  - asynchronous active-low reset, stages clear to 0
//           din      - asynchronous input
//           dout     - synchronised output (last stage)

module fc28_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/fc28_sampler.sv
// rtl/fc28_sampler.sv - duty-cycled, debounced front-end for the FC-28 DO line
//
// Purpose : powers the FC-28 probe only while measuring, waits for the supply
//           to settle, debounces the synchronised DO and holds the last good
//           reading as a clean level for the moisture PIO.
// Ports   : clk, reset_n (async, active-low)
//           enable     - measurement scheduling enabled
//           trigger    - one-cycle request for an immediate measurement
//           sensor_do  - raw asynchronous DO (1 = dry, 0 = wet)
//           sensor_pwr - registered probe supply enable
//           dry        - last accepted reading
//           valid      - a reading has been accepted since reset
//           unstable   - the last measurement timed out
//           sample_stb - one-cycle pulse when a measurement completes
//           busy       - FSM is not idle

module fc28_sampler
  import fc28_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic trigger,
  input  logic sensor_do,
  output logic sensor_pwr,
  output logic dry,
  output logic valid,
  output logic unstable,
  output logic sample_stb,
  output logic busy
);

  localparam int unsigned CNT_W  = cnt_width(max4(SETTLE_CYCLES, PERIOD_CYCLES,
                                                  DEBOUNCE_CYCLES, WINDOW_CYCLES));
  localparam int unsigned STAB_W = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WINDOW_N    = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [STAB_W-1:0] DEBOUNCE_N  = STAB_W'(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ONE    = STAB_W'(1);

  if (DEBOUNCE_CYCLES > WINDOW_CYCLES) begin : g_cfg_check
    $error("fc28_sampler: DEBOUNCE_CYCLES must not exceed WINDOW_CYCLES");
  end

  logic do_s;

  fc28_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sensor_do),
    .dout    (do_s)
  );

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [STAB_W-1:0] stab_q,     stab_d;
  logic              cand_q,     cand_d;
  logic              pwr_q,      pwr_d;
  logic              dry_q,      dry_d;
  logic              valid_q,    valid_d;
  logic              unstable_q, unstable_d;
  logic              stb_q,      stb_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stab_d     = stab_q;
    cand_d     = cand_q;
    dry_d      = dry_q;
    valid_d    = valid_q;
    unstable_d = unstable_q;

    if (!enable) begin
      // Abort without a strobe; held results stay as they were.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!valid_q || trigger || (cnt_q == PERIOD_LAST)) begin
            state_d = ST_PWRUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_PWRUP: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_SAMPLE: begin
          // The counter doubles as the window counter; a value of one marks
          // the first SAMPLE cycle, where the candidate is (re)loaded so
          // do_s is only ever looked at inside SAMPLE.
          if (cnt_q == CNT_ONE) begin
            cand_d = do_s;
            stab_d = STAB_ONE;
          end else if (do_s == cand_q) begin
            stab_d = stab_q + 1'b1;
          end else begin
            cand_d = do_s;
            stab_d = STAB_ONE;
          end

          // Result flags are updated on the way into DONE_* so they are
          // already valid while sample_stb is high. A stable value wins
          // over a window expiry in the same cycle.
          if (stab_d == DEBOUNCE_N) begin
            state_d    = ST_DONE_OK;
            dry_d      = cand_d;
            valid_d    = 1'b1;
            unstable_d = 1'b0;
          end else if (cnt_q == WINDOW_N) begin
            state_d    = ST_DONE_ERR;
            unstable_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DONE_OK, ST_DONE_ERR: begin
          // Period is timed from here, the end of the measurement.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    pwr_d = (state_d == ST_PWRUP) || (state_d == ST_SAMPLE);
    stb_d = (state_d == ST_DONE_OK) || (state_d == ST_DONE_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stab_q     <= '0;
      cand_q     <= 1'b0;
      pwr_q      <= 1'b0;
      dry_q      <= 1'b0;
      valid_q    <= 1'b0;
      unstable_q <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      cand_q     <= cand_d;
      pwr_q      <= pwr_d;
      dry_q      <= dry_d;
      valid_q    <= valid_d;
      unstable_q <= unstable_d;
      stb_q      <= stb_d;
    end
  end

  assign sensor_pwr = pwr_q;
  assign dry        = dry_q;
  assign valid      = valid_q;
  assign unstable   = unstable_q;
  assign sample_stb = stb_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc28_sampler.sv
// tb/tb_fc28_sampler.sv - scoreboard testbench for fc28_sampler

module tb_fc28_sampler;

  localparam int SETTLE   = 4;
  localparam int PERIOD   = 20;
  localparam int DEBOUNCE = 3;
  localparam int WINDOW   = 10;
  localparam int SYNC     = 2;

  // Probe-on time of a clean measurement and the extra edge between the
  // strobe and the first IDLE cycle.
  localparam int LEN_CLEAN  = SETTLE + DEBOUNCE;       // 7
  localparam int LEN_GLITCH = SETTLE + DEBOUNCE + 3;   // 10
  localparam int LEN_ERR    = SETTLE + WINDOW;         // 14
  localparam int GAP_STB    = PERIOD + 1;              // 21
  localparam int GAP_REEN   = PERIOD;                  // 20

  logic clk = 1'b0;
  logic reset_n, enable, trigger, sensor_do;
  logic sensor_pwr, dry, valid, unstable, sample_stb, busy;

  always #5 clk = ~clk;

  fc28_sampler #(
    .SETTLE_CYCLES   (SETTLE),
    .PERIOD_CYCLES   (PERIOD),
    .DEBOUNCE_CYCLES (DEBOUNCE),
    .WINDOW_CYCLES   (WINDOW),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .trigger    (trigger),
    .sensor_do  (sensor_do),
    .sensor_pwr (sensor_pwr),
    .dry        (dry),
    .valid      (valid),
    .unstable   (unstable),
    .sample_stb (sample_stb),
    .busy       (busy)
  );

  typedef struct {
    logic dry;
    logic valid;
    logic unstable;
    int   len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic d, input logic v, input logic u, input int len);
    exp_t e;
    e.dry = d; e.valid = v; e.unstable = u; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: measures how long sensor_pwr was high and checks every strobe
  // against the oldest queued expectation.
  int pwr_run  = 0;
  int last_len = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sensor_pwr === 1'b1) pwr_run++;
      else if (pwr_run != 0) begin
        last_len = pwr_run;
        pwr_run  = 0;
      end
      if (sample_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stb_unexpected: got sample_stb=1 expected no strobe");
        end else begin
          e = exp_q.pop_front();
          check("stb_dry",      int'(dry),      int'(e.dry));
          check("stb_valid",    int'(valid),    int'(e.valid));
          check("stb_unstable", int'(unstable), int'(e.unstable));
          check("stb_pwr_len",  last_len,       e.len);
        end
      end
    end
  end

  task automatic wait_stb(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got no sample_stb expected one within 100 cycles", name);
  endtask

  // Negedges up to and including the first one with sensor_pwr high.
  task automatic edges_to_pwr(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (sensor_pwr === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    int  n;
    bit  seen;

    reset_n   = 1'b0;
    enable    = 1'b1;
    trigger   = 1'b0;
    sensor_do = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwr",      int'(sensor_pwr), 0);
    check("rst_dry",      int'(dry),        0);
    check("rst_valid",    int'(valid),      0);
    check("rst_unstable", int'(unstable),   0);
    check("rst_stb",      int'(sample_stb), 0);
    check("rst_busy",     int'(busy),       0);

    // 1: first measurement starts straight after reset, DO held dry.
    push_exp(1'b1, 1'b1, 1'b0, LEN_CLEAN);
    reset_n = 1'b1;
    @(negedge clk);
    check("t1_pwr_start", int'(sensor_pwr), 1);
    check("t1_busy",      int'(busy),       1);
    wait_stb("t1_stb");

    // 3: DO toggling every cycle times out, dry keeps 1.
    push_exp(1'b1, 1'b1, 1'b1, LEN_ERR);
    edges_to_pwr(n);
    check("t1_idle_gap", n, GAP_STB);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) begin
        seen = 1'b1;
        break;
      end
      sensor_do = ~sensor_do;
    end
    check("t3_stb_seen", int'(seen), 1);

    // 2: wet reading with a one-cycle glitch in the third SAMPLE cycle;
    // also clears unstable.
    sensor_do = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0, LEN_GLITCH);
    edges_to_pwr(n);
    check("t3_idle_gap", n, GAP_STB);
    repeat (4) @(negedge clk);
    sensor_do = 1'b1;
    @(negedge clk);
    sensor_do = 1'b0;
    wait_stb("t2_stb");

    // 4: trigger in IDLE starts at once; trigger in SAMPLE is dropped.
    push_exp(1'b0, 1'b1, 1'b0, LEN_CLEAN);
    repeat (6) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("t4_trig_start", int'(sensor_pwr), 1);
    repeat (5) @(negedge clk);
    check("t4_busy_sample", int'(busy), 1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_stb("t4_stb");
    edges_to_pwr(n);
    check("t4_idle_gap", n, GAP_STB);

    // 5: enable dropped during PWRUP aborts without a strobe.
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t5_pwr_off",  int'(sensor_pwr), 0);
    check("t5_busy",     int'(busy),       0);
    check("t5_dry",      int'(dry),        0);
    check("t5_valid",    int'(valid),      1);
    check("t5_unstable", int'(unstable),   0);
    repeat (5) @(negedge clk);
    check("t5_pwr_idle", int'(sensor_pwr), 0);
    enable = 1'b1;
    edges_to_pwr(n);
    check("t5_reen_gap", n, GAP_REEN);

    // 6: async reset in SAMPLE, then an immediate fresh measurement.
    repeat (5) @(negedge clk);
    check("t6_busy_sample", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_pwr",   int'(sensor_pwr), 0);
    check("t6_rst_dry",   int'(dry),        0);
    check("t6_rst_valid", int'(valid),      0);
    check("t6_rst_busy",  int'(busy),       0);
    push_exp(1'b0, 1'b1, 1'b0, LEN_CLEAN);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_restart", int'(sensor_pwr), 1);
    wait_stb("t6_stb");
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
